product_display: RTL and testbench

//  Downstream stage of the multiply/RAM controller: takes the product read back from RAM plus the

---
 rtl/product_display_pkg.sv | 30 +++
 rtl/product_display_bin2bcd_seq.sv | 74 +++++++
 rtl/product_display.sv | 83 ++++++++
 tb/tb_product_display.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/product_display_pkg.sv
// Shared display definitions: converter state encoding, seven-segment glyph table and
// the double-dabble nibble adjust step.
package product_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}, indexed by the hex value 0..F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/product_display_bin2bcd_seq.sv
// Sequential double-dabble binary to 3-digit BCD converter. The visible result only
// updates in DONE, so a half-converted value never reaches the output.
module bin2bcd_seq
  import product_display_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic [11:0]       bcd
);

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [11:0]       scratch_q, scratch_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [11:0]       adj;

  assign adj = dd_adjust(scratch_q);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d     = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Adjust first, then shift {scratch,bin} left as one long register.
        scratch_d = {adj[10:0], bin_q[DATA_W-1]};
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'(DATA_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/product_display.sv
// Shows the controller state (hex, digit 3) and the RAM product (decimal, digits 2..0)
// on a 4-digit multiplexed active-low seven-segment display.
module product_display
  import product_display_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic [3:0]        st_in,
  output logic              busy,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [11:0]   bcd_disp;
  logic [3:0]    st_q;
  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    hundreds, tens, ones;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .bin     (data_in),
    .busy    (busy),
    .bcd     (bcd_disp)
  );

  assign hundreds = bcd_disp[11:8];
  assign tens     = bcd_disp[7:4];
  assign ones     = bcd_disp[3:0];

  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == CW'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // Leading-zero blanking: tens only blank when hundreds is also zero.
  always_comb begin
    an_d = ~(4'b0001 << idx_q);
    case (idx_q)
      2'd0:    seg_d = SEG_GLYPH[ones];
      2'd1:    seg_d = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : SEG_GLYPH[tens];
      2'd2:    seg_d = (hundreds == 4'd0) ? SEG_BLANK : SEG_GLYPH[hundreds];
      default: seg_d = SEG_GLYPH[st_q];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= '0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      st_q      <= st_in;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_product_display.sv
// Directed self-checking bench for product_display with a fast refresh divider.
module tb_product_display;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              load = 1'b0;
  logic [3:0]        st_in = 4'd0;
  logic              busy;
  logic [3:0]        an;
  logic [6:0]        seg;
  logic              dp;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;

  product_display #(.DATA_W(DATA_W), .REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .load    (load),
    .st_in   (st_in),
    .busy    (busy),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  // Waits (bounded) until digit d is lit and returns its segments.
  task automatic read_digit(input int d, output logic [6:0] s, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    ok = 1'b0;
    s = 'x;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (an === want) begin
        s = seg;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_digit(input string name, input int d, input logic [6:0] exp);
    logic [6:0] s;
    bit ok;
    read_digit(d, s, ok);
    checks++;
    if (!ok || s !== exp) begin
      errors++;
      $display("FAIL %s digit%0d: seg=%b found=%0d required=%b", name, d, s, ok, exp);
    end else
      $display("check %s digit%0d seg=%b ok", name, d, s);
  endtask

  // Issues a one-cycle load; returns at the negedge after the accepting edge.
  task automatic start_conv(input logic [DATA_W-1:0] v);
    @(negedge clk);
    data_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_busy(input string name, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== exp) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d required %0d", name, n, exp);
    end else
      $display("check %s busy cycles=%0d ok", name, n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== BL || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset: busy=%b an=%b seg=%b dp=%b required 0 1111 1111111 1", busy, an, seg, dp);
    end else
      $display("check reset outputs ok");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL first_an: an=%b required 1110", an);
    end else
      $display("check first_an an=%b ok", an);
  endtask

  task automatic test_255();
    start_conv(8'd255);
    count_busy("conv255", 9);
    check_digit("conv255", 2, G2);
    check_digit("conv255", 1, G5);
    check_digit("conv255", 0, G5);
  endtask

  task automatic test_7();
    start_conv(8'd7);
    count_busy("conv7", 9);
    check_digit("conv7", 2, BL);
    check_digit("conv7", 1, BL);
    check_digit("conv7", 0, G7);
  endtask

  task automatic test_zero_state();
    st_in = 4'd5;
    start_conv(8'd0);
    count_busy("conv0", 9);
    check_digit("conv0", 0, G0);
    check_digit("conv0", 1, BL);
    check_digit("conv0", 2, BL);
    check_digit("state5", 3, G5);
  endtask

  task automatic test_load_dropped();
    int n = 0;
    int extra = 0;
    start_conv(8'd200);
    while (busy === 1'b1 && n < 30) begin
      if (n == 2) begin
        data_in = 8'd99;
        load = 1'b1;
      end else
        load = 1'b0;
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL drop busy cycles: got %0d required 9", n);
    end else
      $display("check drop busy cycles=%0d ok", n);
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL drop second_busy: busy cycles %0d required 0", extra);
    end else
      $display("check drop no second busy ok");
    check_digit("drop200", 2, G2);
    check_digit("drop200", 1, G0);
    check_digit("drop200", 0, G0);
  endtask

  task automatic test_refresh();
    logic [3:0] seq [5];
    logic [3:0] prev;
    int n;
    int guard = 0;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;
    // Align to the start of a digit-0 period.
    prev = an;
    @(negedge clk);
    while (!(an === 4'b1110 && prev === 4'b0111) && guard < 40) begin
      prev = an;
      guard++;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (an === seq[k] && n < 10) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL refresh hold an=%b: held %0d cycles required 4", seq[k], n);
      end else
        $display("check refresh an=%b held %0d ok", seq[k], n);
    end
    checks++;
    if (an !== seq[4]) begin
      errors++;
      $display("FAIL refresh wrap: an=%b required %b", an, seq[4]);
    end else
      $display("check refresh wrap an=%b ok", an);
  endtask

  task automatic test_async_reset();
    st_in = 4'd0;
    start_conv(8'd255);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== BL) begin
      errors++;
      $display("FAIL async_reset: busy=%b an=%b seg=%b required 0 1111 1111111", busy, an, seg);
    end else
      $display("check async_reset outputs ok");
    @(negedge clk);
    reset_n = 1'b1;
    check_digit("after_reset", 0, G0);
    check_digit("after_reset", 1, BL);
    check_digit("after_reset", 2, BL);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset busy: busy=%b required 0", busy);
    end else
      $display("check after_reset busy=0 ok");
  endtask

  initial begin
    test_reset();
    test_255();
    test_7();
    test_zero_state();
    test_load_dropped();
    test_refresh();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
